// File: rtl/eks_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : eks_scheduler
// Brief    : Sequencer for bcrypt EksBlowfishSetup and the final encipher
//            passes. It issues expandKey and encipher start pulses only.
// Revision : 1.0 - initial release
// ============================================================================
module eks_scheduler #(
    parameter int MIN_COST   = 4,
    parameter int MAX_COST   = 31,
    parameter int ENC_ROUNDS = 64,
    parameter int ENC_BLOCKS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [4:0]                cost,
    input  logic [127:0]              salt,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      ek_start,
    output logic                      ek_load_salt,
    output logic [127:0]              ek_salt,
    output logic                      ek_key_sel,
    input  logic                      ek_done,
    output logic                      enc_start,
    output logic [31:0]               enc_L,
    output logic [31:0]               enc_R,
    input  logic [31:0]               enc_resultL,
    input  logic [31:0]               enc_resultR,
    input  logic                      enc_done,
    output logic [64*ENC_BLOCKS-1:0]  ctext
);

    localparam int c_RND_W = (ENC_ROUNDS > 1) ? $clog2(ENC_ROUNDS) : 1;
    localparam int c_BLK_W = (ENC_BLOCKS > 1) ? $clog2(ENC_BLOCKS) : 1;
    localparam logic [64*ENC_BLOCKS-1:0] c_MAGIC =
        192'h4f727068_65616e42_65686f6c_64657253_63727944_6f756274;

    typedef enum logic [3:0] {
        S_IDLE, S_EK0_START, S_EK0_WAIT, S_LK_START, S_LK_WAIT,
        S_LS_START, S_LS_WAIT, S_ENC_START, S_ENC_WAIT, S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [127:0]         r_salt;
    logic [4:0]           r_cost;
    logic [31:0]          r_iter;
    logic [c_RND_W-1:0]   r_rnd;
    logic [c_BLK_W-1:0]   r_blk;
    logic [63:0]          r_blocks [ENC_BLOCKS];
    logic                 r_err;

    logic [31:0]          w_cost_ext;
    logic                 w_cost_ok;
    logic [31:0]          w_iter_last;
    logic                 w_last_rnd;
    logic                 w_last_blk;

    assign w_cost_ext  = {27'd0, cost};
    assign w_cost_ok   = (w_cost_ext >= 32'(MIN_COST)) && (w_cost_ext <= 32'(MAX_COST));
    // Shift stays inside 32 bits even for cost 31, so the limit is 0x7FFFFFFF.
    assign w_iter_last = (32'd1 << r_cost) - 32'd1;
    assign w_last_rnd  = (r_rnd == c_RND_W'(ENC_ROUNDS - 1));
    assign w_last_blk  = (r_blk == c_BLK_W'(ENC_BLOCKS - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start && w_cost_ok) w_next = S_EK0_START;
            S_EK0_START: w_next = S_EK0_WAIT;
            S_EK0_WAIT:  if (ek_done) w_next = S_LK_START;
            S_LK_START:  w_next = S_LK_WAIT;
            S_LK_WAIT:   if (ek_done) w_next = S_LS_START;
            S_LS_START:  w_next = S_LS_WAIT;
            S_LS_WAIT:   if (ek_done) w_next = (r_iter == w_iter_last) ? S_ENC_START : S_LK_START;
            S_ENC_START: w_next = S_ENC_WAIT;
            S_ENC_WAIT:  if (enc_done) w_next = (w_last_rnd && w_last_blk) ? S_DONE : S_ENC_START;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_salt <= '0;
            r_cost <= '0;
            r_iter <= '0;
            r_rnd  <= '0;
            r_blk  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < ENC_BLOCKS; i++) r_blocks[i] <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_cost_ok) begin
                        r_salt <= salt;
                        r_cost <= cost;
                        r_iter <= '0;
                        r_rnd  <= '0;
                        r_blk  <= '0;
                        for (int i = 0; i < ENC_BLOCKS; i++)
                            r_blocks[i] <= c_MAGIC[64*(ENC_BLOCKS-i)-1 -: 64];
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                S_LS_WAIT: begin
                    if (ek_done) begin
                        if (r_iter == w_iter_last) begin
                            r_rnd <= '0;
                            r_blk <= '0;
                        end else begin
                            r_iter <= r_iter + 32'd1;
                        end
                    end
                end
                S_ENC_WAIT: begin
                    if (enc_done) begin
                        r_blocks[r_blk] <= {enc_resultL, enc_resultR};
                        if (!w_last_rnd) begin
                            r_rnd <= r_rnd + c_RND_W'(1);
                        end else begin
                            r_rnd <= '0;
                            r_blk <= w_last_blk ? '0 : r_blk + c_BLK_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are decoded from state so they hold through the WAIT states.
    always_comb begin
        busy         = (r_state != S_IDLE) && (r_state != S_DONE);
        done         = (r_state == S_DONE);
        err          = r_err;
        ek_start     = (r_state == S_EK0_START) || (r_state == S_LK_START) || (r_state == S_LS_START);
        ek_load_salt = ek_start;
        ek_key_sel   = (r_state == S_LS_START) || (r_state == S_LS_WAIT);
        ek_salt      = '0;
        if ((r_state == S_EK0_START) || (r_state == S_EK0_WAIT)) ek_salt = r_salt;
        enc_start    = (r_state == S_ENC_START);
        enc_L        = '0;
        enc_R        = '0;
        if ((r_state == S_ENC_START) || (r_state == S_ENC_WAIT))
            {enc_L, enc_R} = r_blocks[r_blk];
    end

    for (genvar i = 0; i < ENC_BLOCKS; i++) begin : g_ctext
        assign ctext[64*(ENC_BLOCKS-i)-1 -: 64] = r_blocks[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_eks_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_eks_scheduler
// Brief    : Directed bench for eks_scheduler with latency-configurable stubs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eks_scheduler;

    localparam logic [191:0] c_MAGIC =
        192'h4f727068_65616e42_65686f6c_64657253_63727944_6f756274;
    // Add-stub result: L gains 64, R gains 128 over 64 rounds.
    localparam logic [191:0] c_ADDED =
        192'h4f7270a8_65616ec2_65686fac_646572d3_63727984_6f7562f4;
    localparam logic [127:0] c_SALT_A = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] c_SALT_B = 128'hdeadbeefcafef00d_5a5aa5a5c3c33c3c;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   cost = 5'd0;
    logic [127:0] salt = '0;
    logic         busy, done, err, ek_start, ek_load_salt, ek_key_sel, enc_start;
    logic [127:0] ek_salt;
    logic         ek_done = 1'b0;
    logic         enc_done = 1'b0;
    logic [31:0]  enc_L, enc_R;
    logic [31:0]  enc_resultL = '0;
    logic [31:0]  enc_resultR = '0;
    logic [191:0] ctext;

    int checks = 0;
    int errors = 0;

    int ek_lat = 3, enc_lat = 3, enc_mode = 0;
    bit spurious_en = 1'b0;
    int ek_cnt = 0, enc_cnt = 0, done_cnt = 0, pat_err = 0, busy_err = 0;
    logic [127:0] exp_salt = '0;
    bit ek_armed = 1'b0, enc_armed = 1'b0, spur_pending = 1'b0;
    int ek_wait = 0, enc_wait = 0;
    logic [31:0] cap_L = '0, cap_R = '0;

    eks_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .cost(cost), .salt(salt),
        .busy(busy), .done(done), .err(err),
        .ek_start(ek_start), .ek_load_salt(ek_load_salt), .ek_salt(ek_salt),
        .ek_key_sel(ek_key_sel), .ek_done(ek_done),
        .enc_start(enc_start), .enc_L(enc_L), .enc_R(enc_R),
        .enc_resultL(enc_resultL), .enc_resultR(enc_resultR), .enc_done(enc_done),
        .ctext(ctext)
    );

    always #5 clk = ~clk;

    // Engine stubs and protocol monitor, all acting on the falling edge.
    always @(negedge clk) begin
        ek_done  = 1'b0;
        enc_done = 1'b0;
        if (reset) begin
            ek_armed = 1'b0; enc_armed = 1'b0; spur_pending = 1'b0;
        end else begin
            if (ek_armed) begin
                if (ek_wait == 0) begin ek_done = 1'b1; ek_armed = 1'b0; end
                else ek_wait--;
            end
            if (enc_armed) begin
                if (enc_wait == 0) begin
                    enc_done = 1'b1; enc_armed = 1'b0;
                    if (enc_mode == 0) begin enc_resultL = cap_R;         enc_resultR = cap_L;         end
                    else               begin enc_resultL = cap_L + 32'd1; enc_resultR = cap_R + 32'd2; end
                end else enc_wait--;
            end
            if (spur_pending) begin ek_done = 1'b1; spur_pending = 1'b0; end
            if (ek_start) begin
                if (ek_load_salt !== 1'b1) pat_err++;
                if (ek_cnt == 0) begin
                    if (ek_salt !== exp_salt || ek_key_sel !== 1'b0) pat_err++;
                end else if (ek_salt !== 128'd0 || ek_key_sel !== ((ek_cnt % 2) == 0)) begin
                    pat_err++;
                end
                ek_cnt++; ek_armed = 1'b1; ek_wait = ek_lat;
            end
            if (enc_start) begin
                enc_cnt++; cap_L = enc_L; cap_R = enc_R;
                enc_armed = 1'b1; enc_wait = enc_lat;
                if (spurious_en) spur_pending = 1'b1;
            end
            if (done) done_cnt++;
            if ((ek_start || enc_start) && busy !== 1'b1) busy_err++;
            if (done && busy !== 1'b0) busy_err++;
        end
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_counts();
        ek_cnt = 0; enc_cnt = 0; done_cnt = 0; pat_err = 0; busy_err = 0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        chk(tag, 192'(seen), 192'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy_done_err", {busy, done, err}, 3'b000);
        chk("rst_starts_keysel", {ek_start, ek_load_salt, enc_start, ek_key_sel}, 4'b0000);
        chk("rst_ek_salt", ek_salt, 128'd0);
        chk("rst_enc_LR", {enc_L, enc_R}, 64'd0);
        chk("rst_ctext", ctext, 192'd0);
        reset = 1'b0;
        tick();

        // Out-of-range costs: error pulse only
        clear_counts();
        cost = 5'd3; start = 1'b1; salt = c_SALT_A;
        tick(); start = 1'b0;
        chk("cost3_err", {err, busy}, 2'b10);
        tick();
        chk("cost3_err_pulse", {err, busy}, 2'b00);
        cost = 5'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("cost0_err", {err, busy}, 2'b10);
        repeat (3) tick();
        chk("cost0_err_pulse", {err, busy}, 2'b00);
        chk("bad_cost_no_ek", 192'(ek_cnt), 192'd0);

        // Run 1: cost 4, 3-cycle stubs, swapping encipher
        clear_counts();
        ek_lat = 3; enc_lat = 3; enc_mode = 0; exp_salt = c_SALT_A;
        cost = 5'd4; salt = c_SALT_A; start = 1'b1;
        tick(); start = 1'b0;
        chk("run1_busy", {busy, err}, 2'b10);
        chk("run1_magic", ctext, c_MAGIC);
        wait_done("run1_done");
        chk("run1_busy_at_done", 192'(busy), 192'd0);
        chk("run1_ek_count", 192'(ek_cnt), 192'd33);
        chk("run1_enc_count", 192'(enc_cnt), 192'd192);
        chk("run1_ctext", ctext, c_MAGIC);

        // Back-to-back run: start in the IDLE cycle after done, held high,
        // zero-latency stubs, spurious ek_done during ENC_WAIT
        tick();
        chk("run1_done_pulse", 192'(done), 192'd0);
        chk("run1_done_cnt", 192'(done_cnt), 192'd1);
        chk("run1_pattern", 192'(pat_err), 192'd0);
        chk("run1_busy_frame", 192'(busy_err), 192'd0);
        clear_counts();
        ek_lat = 0; enc_lat = 0; enc_mode = 1; spurious_en = 1'b1; exp_salt = c_SALT_B;
        salt = c_SALT_B; cost = 5'd4; start = 1'b1;
        tick();
        chk("b2b_busy", 192'(busy), 192'd1);
        wait_done("b2b_done");
        start = 1'b0;
        chk("b2b_ek_count", 192'(ek_cnt), 192'd33);
        chk("b2b_enc_count", 192'(enc_cnt), 192'd192);
        chk("b2b_ctext", ctext, c_ADDED);
        tick();
        chk("b2b_done_cnt", 192'(done_cnt), 192'd1);
        chk("b2b_pattern", 192'(pat_err), 192'd0);
        tick();
        chk("b2b_no_restart", {busy, done}, 2'b00);
        chk("b2b_busy_frame", 192'(busy_err), 192'd0);
        spurious_en = 1'b0;

        // Reset while in LS_WAIT with iter 5 (13th ek_start), then full rerun
        clear_counts();
        ek_lat = 3; enc_lat = 3; enc_mode = 0; exp_salt = c_SALT_A;
        salt = c_SALT_A; cost = 5'd4; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 500 && ek_cnt < 13; i++) tick();
        chk("abort_reached_ls", 192'(ek_cnt), 192'd13);
        chk("abort_ls_wait_keysel", {busy, ek_key_sel}, 2'b11);
        reset = 1'b1;
        tick();
        chk("abort_flags", {busy, done, err, ek_start, enc_start, ek_key_sel}, 6'd0);
        chk("abort_ctext", ctext, 192'd0);
        chk("abort_ek_salt", ek_salt, 128'd0);
        reset = 1'b0;
        tick();
        clear_counts();
        start = 1'b1;
        tick(); start = 1'b0;
        wait_done("rerun_done");
        chk("rerun_ek_count", 192'(ek_cnt), 192'd33);
        chk("rerun_enc_count", 192'(enc_cnt), 192'd192);
        chk("rerun_ctext", ctext, c_MAGIC);
        tick();
        chk("rerun_pattern", 192'(pat_err), 192'd0);

        // cost 31 is accepted; abort shortly after launch
        clear_counts();
        exp_salt = c_SALT_B; salt = c_SALT_B; cost = 5'd31; start = 1'b1;
        tick(); start = 1'b0;
        chk("cost31_accept", {busy, err, ek_start}, 3'b101);
        chk("cost31_salt", ek_salt, c_SALT_B);
        repeat (20) tick();
        chk("cost31_still_busy", 192'(busy), 192'd1);
        reset = 1'b1;
        tick();
        chk("cost31_abort", 192'(busy), 192'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
